// File: rtl/rom_fetch.sv
// rom_fetch: fetches one- and two-byte instructions from a combinational ROM
// and presents them to a decoder over a valid/ready handshake.
//
// Handshake: o_valid is asserted only in PRESENT and then holds o_instr,
// o_operand, o_two_byte and o_pc stable. The instruction is consumed at the
// rising edge where o_valid && i_ready are both 1, unless i_redir is also 1
// (redirect wins and the instruction is dropped). o_valid never depends
// combinationally on i_ready.
//
// o_state exposes the FSM state for observation
// (0 IDLE, 1 FETCH_OP, 2 FETCH_ARG, 3 PRESENT, 4 HALT).
module rom_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_redir,
    input  logic [7:0] i_redir_addr,
    output logic [7:0] o_addr,
    output logic       o_ren,
    output logic       o_cen,
    input  logic [7:0] i_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_instr,
    output logic [7:0] o_operand,
    output logic       o_two_byte,
    output logic [7:0] o_pc,
    output logic       o_halted,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_ARG = 3'd2,
        PRESENT   = 3'd3,
        HALT      = 3'd4
    } state_t;

    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] operand_q, operand_d;
    logic       two_byte_q, two_byte_d;
    logic [7:0] op_pc_q, op_pc_d;
    logic       is_two_byte;

    // Opcodes that carry an operand byte
    always_comb begin
        is_two_byte = (i_data[7:5] == OP_LDO) ||
                      (i_data[7:5] == OP_LDA) ||
                      (i_data[7:5] == OP_STO);
    end

    // State and datapath registers; reset overrides every other input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 8'h00;
            operand_q  <= 8'h00;
            two_byte_q <= 1'b0;
            op_pc_q    <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            operand_q  <= operand_d;
            two_byte_q <= two_byte_d;
            op_pc_q    <= op_pc_d;
        end
    end

    // Next-state and datapath updates; i_data is only captured in fetch states
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        operand_d  = operand_q;
        two_byte_d = two_byte_q;
        op_pc_d    = op_pc_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FETCH_OP;
                end
            end
            FETCH_OP: begin
                if (i_redir) begin
                    pc_d    = i_redir_addr;
                    state_d = FETCH_OP;
                end else begin
                    instr_d    = i_data;
                    op_pc_d    = pc_q;
                    pc_d       = pc_q + 8'd1;
                    operand_d  = 8'h00;
                    two_byte_d = 1'b0;
                    state_d    = is_two_byte ? FETCH_ARG : PRESENT;
                end
            end
            FETCH_ARG: begin
                if (i_redir) begin
                    pc_d    = i_redir_addr;
                    state_d = FETCH_OP;
                end else begin
                    operand_d  = i_data;
                    two_byte_d = 1'b1;
                    pc_d       = pc_q + 8'd1;
                    state_d    = PRESENT;
                end
            end
            PRESENT: begin
                if (i_redir) begin
                    pc_d    = i_redir_addr;
                    state_d = FETCH_OP;
                end else if (i_ready) begin
                    state_d = (instr_q[7:5] == OP_HLT) ? HALT : FETCH_OP;
                end
            end
            HALT: begin
                if (i_redir) begin
                    pc_d    = i_redir_addr;
                    state_d = FETCH_OP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        o_addr     = pc_q;
        o_ren      = (state_q == FETCH_OP) || (state_q == FETCH_ARG);
        o_cen      = (state_q == FETCH_OP) || (state_q == FETCH_ARG);
        o_valid    = (state_q == PRESENT);
        o_halted   = (state_q == HALT);
        o_instr    = instr_q;
        o_operand  = operand_q;
        o_two_byte = two_byte_q;
        o_pc       = op_pc_q;
        o_state    = state_q;
    end

endmodule

// File: tb/tb_rom_fetch.sv
// Testbench for rom_fetch: ROM model, directed program, scoreboard of
// presented instructions and directed checks on latency, stall, halt,
// redirect, wrap and reset.
module tb_rom_fetch;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH_OP  = 3'd1;
  localparam logic [2:0] S_FETCH_ARG = 3'd2;

  logic       i_clk;
  logic       i_rst;
  logic       i_start;
  logic       i_redir;
  logic [7:0] i_redir_addr;
  logic [7:0] o_addr;
  logic       o_ren;
  logic       o_cen;
  wire  [7:0] i_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_instr;
  logic [7:0] o_operand;
  logic       o_two_byte;
  logic [7:0] o_pc;
  logic       o_halted;
  logic [2:0] o_state;

  logic [7:0] rom [256];
  logic [24:0] exp_q[$];   // {pc, instr, operand, two_byte}
  int checks;
  int errors;

  rom_fetch dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (i_start),
    .i_redir      (i_redir),
    .i_redir_addr (i_redir_addr),
    .o_addr       (o_addr),
    .o_ren        (o_ren),
    .o_cen        (o_cen),
    .i_data       (i_data),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_instr      (o_instr),
    .o_operand    (o_operand),
    .o_two_byte   (o_two_byte),
    .o_pc         (o_pc),
    .o_halted     (o_halted),
    .o_state      (o_state)
  );

  assign i_data = (o_ren && o_cen) ? rom[o_addr] : 8'hzz;

  // clock / reset
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] pc, input logic [7:0] ins,
                          input logic [7:0] opd, input logic tb);
    exp_q.push_back({pc, ins, opd, tb});
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_fetch(input logic [7:0] a, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(o_ren && o_addr == a) && n < 200);
    chk(name, {31'd0, (o_ren && o_addr == a)}, 32'd1);
  endtask

  // scoreboard monitor: pops on every accepted handshake
  always @(negedge i_clk) begin
    logic [24:0] e;
    if (!i_rst && o_valid && i_ready && !i_redir) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc=%0h instr=%0h, expected nothing", o_pc, o_instr);
      end else begin
        e = exp_q.pop_front();
        if ({o_pc, o_instr, o_operand, o_two_byte} !== e) begin
          errors++;
          $display("FAIL sb_instr: got pc=%0h instr=%0h opd=%0h tb=%0b expected pc=%0h instr=%0h opd=%0h tb=%0b",
                   o_pc, o_instr, o_operand, o_two_byte, e[24:17], e[16:9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]  = 8'h00;
    rom[1]  = 8'h21; rom[2] = 8'h41;
    rom[3]  = 8'h80;
    rom[4]  = 8'h45; rom[5] = 8'h12;
    rom[6]  = 8'h6A; rom[7] = 8'hFF;
    for (int i = 8; i <= 18; i++) rom[i] = 8'hA0 + 8'(i);
    rom[19] = 8'hE0;
    rom[255] = 8'h3F;

    i_rst = 1'b1; i_start = 1'b0; i_redir = 1'b0; i_redir_addr = 8'h00; i_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_ren", {31'd0, o_ren}, 32'd0);
    chk("rst_cen", {31'd0, o_cen}, 32'd0);
    chk("rst_addr", {24'd0, o_addr}, 32'h00);
    chk("rst_pc", {24'd0, o_pc}, 32'h00);
    chk("rst_instr", {24'd0, o_instr}, 32'h00);
    chk("rst_halted", {31'd0, o_halted}, 32'd0);

    // redirect and ready are ignored in IDLE
    i_rst = 1'b0; i_redir = 1'b1; i_redir_addr = 8'h55; i_ready = 1'b1;
    tick(); tick();
    chk("idle_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("idle_ren", {31'd0, o_ren}, 32'd0);
    i_redir = 1'b0;

    // program order of presented instructions
    push_exp(8'h00, 8'h00, 8'h00, 1'b0);
    push_exp(8'h01, 8'h21, 8'h41, 1'b1);
    push_exp(8'h03, 8'h80, 8'h00, 1'b0);
    push_exp(8'h04, 8'h45, 8'h12, 1'b1);
    push_exp(8'h06, 8'h6A, 8'hFF, 1'b1);
    for (int i = 8; i <= 18; i++) push_exp(8'(i), 8'hA0 + 8'(i), 8'h00, 1'b0);
    push_exp(8'h13, 8'hE0, 8'h00, 1'b0);

    // one-byte latency: FETCH_OP cycle, then o_valid the next cycle
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("lat_fetch_ren", {31'd0, o_ren}, 32'd1);
    chk("lat_fetch_addr", {24'd0, o_addr}, 32'h00);
    tick();
    chk("lat_valid", {31'd0, o_valid}, 32'd1);
    chk("lat_instr", {24'd0, o_instr}, 32'h00);
    chk("lat_two_byte", {31'd0, o_two_byte}, 32'd0);
    chk("lat_pc", {24'd0, o_pc}, 32'h00);

    // backpressure on the instruction at address 3
    wait_fetch(8'h03, "wait_fetch3");
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_instr", {24'd0, o_instr}, 32'h80);
      chk("bp_pc", {24'd0, o_pc}, 32'h03);
      chk("bp_ren_cen", {30'd0, o_ren, o_cen}, 32'd0);
      chk("bp_addr", {24'd0, o_addr}, 32'h04);
    end
    i_ready = 1'b1;
    tick();
    chk("bp_accept_ren", {31'd0, o_ren}, 32'd1);
    chk("bp_accept_addr", {24'd0, o_addr}, 32'h04);

    // run to HLT
    begin
      int n;
      n = 0;
      do begin
        tick();
        n++;
      end while (!o_halted && n < 200);
    end
    chk("halted", {31'd0, o_halted}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halt_quiet", {29'd0, o_valid, o_ren, o_cen}, 32'd0);
    end
    chk("halt_queue_empty", exp_q.size(), 32'd0);

    // redirect out of HALT back to 0
    push_exp(8'h00, 8'h00, 8'h00, 1'b0);
    push_exp(8'h01, 8'h21, 8'h41, 1'b1);
    i_redir = 1'b1; i_redir_addr = 8'h00;
    tick();
    i_redir = 1'b0;
    chk("redir_halted", {31'd0, o_halted}, 32'd0);
    chk("redir_ren", {31'd0, o_ren}, 32'd1);
    chk("redir_addr", {24'd0, o_addr}, 32'h00);

    // redirect to 8'hFF: operand fetched across the wrap
    wait_fetch(8'h03, "wait_fetch3_again");
    push_exp(8'hFF, 8'h3F, 8'h00, 1'b1);
    i_redir = 1'b1; i_redir_addr = 8'hFF;
    tick();
    i_redir = 1'b0;
    chk("wrap_fetch_addr", {24'd0, o_addr}, 32'hFF);
    chk("wrap_valid_drop", {31'd0, o_valid}, 32'd0);
    wait_fetch(8'h01, "wrap_next_fetch");
    chk("wrap_queue_empty", exp_q.size(), 32'd0);

    // reset during FETCH_ARG, with i_start also high
    wait_fetch(8'h02, "wait_fetch_arg");
    chk("pre_rst_state", {29'd0, o_state}, {29'd0, S_FETCH_ARG});
    i_rst = 1'b1; i_start = 1'b1;
    tick();
    i_rst = 1'b0; i_start = 1'b0;
    chk("mid_rst_state", {29'd0, o_state}, {29'd0, S_IDLE});
    chk("mid_rst_addr", {24'd0, o_addr}, 32'h00);
    chk("mid_rst_ren_cen", {30'd0, o_ren, o_cen}, 32'd0);
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_instr", {24'd0, o_instr}, 32'h00);
    chk("mid_rst_operand", {24'd0, o_operand}, 32'h00);
    chk("mid_rst_two_byte", {31'd0, o_two_byte}, 32'd0);
    chk("mid_rst_pc", {24'd0, o_pc}, 32'h00);
    chk("mid_rst_halted", {31'd0, o_halted}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", {29'd0, o_state}, {29'd0, S_IDLE});
      chk("post_rst_ren", {31'd0, o_ren}, 32'd0);
    end
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
